// File: rtl/fixed_point_sqrt_pkg.sv
// Shared definitions for the fixed-point unit: opcodes, square-root FSM
// encodings and helpers that size the iterative root engine.
package fixed_point_sqrt_pkg;

   localparam logic [3:0] FPU_ADD  = 4'd0;
   localparam logic [3:0] FPU_SUB  = 4'd1;
   localparam logic [3:0] FPU_MUL  = 4'd2;
   localparam logic [3:0] FPU_DIV  = 4'd3;
   localparam logic [3:0] FPU_SQRT = 4'd4;

   typedef enum logic [1:0] {
      SQRT_IDLE = 2'b00,
      SQRT_BUSY = 2'b01,
      SQRT_DONE = 2'b10
   } sqrt_state_e;

   // One result bit per iteration; an odd radicand width is padded to even.
   function automatic int sqrt_iter(input int width, input int fbits);
      return (width + fbits + 1) / 2;
   endfunction

   function automatic int sqrt_cnt_w(input int iter);
      return (iter <= 2) ? 1 : $clog2(iter);
   endfunction

endpackage

// File: rtl/fixed_point_sqrt_step.sv
// One combinational restoring square-root iteration: brings two radicand
// bits into the remainder and decides the next root bit.
module fixed_point_sqrt_step
   import fixed_point_sqrt_pkg::*;
#(
   parameter int ITER  = 21,
   parameter int REM_W = ITER + 2
) (
   input  logic [REM_W-1:0] rem_i,
   input  logic [ITER-1:0]  root_i,
   input  logic [1:0]       top2_i,
   output logic [REM_W-1:0] rem_o,
   output logic [ITER-1:0]  root_o
);

   localparam int DIFF_W = REM_W + 3;

   logic [DIFF_W-1:0]        lhs;
   logic [DIFF_W-1:0]        rhs;
   logic signed [DIFF_W-1:0] diff;
   logic                     neg;
   logic                     unused_bits;

   assign lhs  = DIFF_W'({rem_i, top2_i});
   assign rhs  = DIFF_W'({root_i, 2'b01});
   assign diff = $signed(lhs) - $signed(rhs);
   assign neg  = diff[DIFF_W-1];

   // Restoring branch keeps the shifted remainder; invariant rem <= 2*root
   // guarantees the kept value fits back into REM_W bits.
   assign rem_o  = neg ? lhs[REM_W-1:0] : diff[REM_W-1:0];
   assign root_o = {root_i[ITER-2:0], ~neg};

   assign unused_bits = ^{lhs[DIFF_W-1:REM_W], diff[DIFF_W-2:REM_W], root_i[ITER-1]};

endmodule

// File: rtl/fixed_point_sqrt.sv
// Iterative unsigned fixed-point square root: floor(sqrt(operand * 2^FBITS)),
// one result bit per clock, result held until the next accepted start.
module fixed_point_sqrt
   import fixed_point_sqrt_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int FBITS = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] operand,
   output logic [WIDTH-1:0] root,
   output logic             root_ready,
   output logic             busy,
   output logic             error
);

   localparam int ITER  = sqrt_iter(WIDTH, FBITS);
   localparam int RAD_W = 2 * ITER;
   localparam int REM_W = ITER + 2;
   localparam int CNT_W = sqrt_cnt_w(ITER);

   sqrt_state_e      state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             neg_pend_q;
   logic [WIDTH-1:0] root_q;
   logic             ready_q;
   logic             busy_q;
   logic             error_q;

   logic [RAD_W-1:0] rad_q, rad_d;
   logic [REM_W-1:0] rem_q, rem_d;
   logic [ITER-1:0]  acc_q, acc_d;

   logic [REM_W-1:0] rem_nxt;
   logic [ITER-1:0]  acc_nxt;
   logic             can_accept;
   logic             accept;
   logic             accept_neg;
   logic             iterating;

   assign can_accept = (state_q != SQRT_BUSY) && !neg_pend_q;
   assign accept     = can_accept && start && !operand[WIDTH-1];
   assign accept_neg = can_accept && start &&  operand[WIDTH-1];
   assign iterating  = (state_q == SQRT_BUSY);

   fixed_point_sqrt_step #(
      .ITER  (ITER),
      .REM_W (REM_W)
   ) u_step (
      .rem_i  (rem_q),
      .root_i (acc_q),
      .top2_i (rad_q[RAD_W-1 -: 2]),
      .rem_o  (rem_nxt),
      .root_o (acc_nxt)
   );

   // Datapath: load the shifted radicand on accept, otherwise iterate.
   always_comb begin
      rad_d = rad_q;
      rem_d = rem_q;
      acc_d = acc_q;
      if (accept) begin
         rad_d = RAD_W'(operand) << FBITS;
         rem_d = '0;
         acc_d = '0;
      end else if (iterating) begin
         rad_d = rad_q << 2;
         rem_d = rem_nxt;
         acc_d = acc_nxt;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rad_q <= '0;
         rem_q <= '0;
         acc_q <= '0;
      end else begin
         rad_q <= rad_d;
         rem_q <= rem_d;
         acc_q <= acc_d;
      end
   end

   // Control FSM with registered outputs; a negative radicand spends one
   // pending cycle before reporting so busy never rises for it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= SQRT_IDLE;
         cnt_q      <= '0;
         neg_pend_q <= 1'b0;
         root_q     <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         case (state_q)
            SQRT_IDLE, SQRT_DONE: begin
               if (neg_pend_q) begin
                  neg_pend_q <= 1'b0;
                  state_q    <= SQRT_DONE;
                  root_q     <= '0;
                  ready_q    <= 1'b1;
                  error_q    <= 1'b1;
               end else if (accept_neg) begin
                  neg_pend_q <= 1'b1;
                  ready_q    <= 1'b0;
                  error_q    <= 1'b0;
               end else if (accept) begin
                  state_q <= SQRT_BUSY;
                  cnt_q   <= CNT_W'(ITER - 1);
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
                  error_q <= 1'b0;
               end
            end
            SQRT_BUSY: begin
               if (cnt_q == '0) begin
                  state_q <= SQRT_DONE;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
                  root_q  <= WIDTH'(acc_nxt);
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: begin
               state_q <= SQRT_IDLE;
               busy_q  <= 1'b0;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   assign root       = root_q;
   assign root_ready = ready_q;
   assign busy       = busy_q;
   assign error      = error_q;

endmodule

// File: tb/tb_fixed_point_sqrt.sv
// Randomized and directed bench for fixed_point_sqrt against an integer
// square-root reference model.
module tb_fixed_point_sqrt;

   localparam int WIDTH = 32;
   localparam int FBITS = 10;
   localparam int ITER  = 21;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] operand;
   logic [31:0] root;
   logic        root_ready;
   logic        busy;
   logic        error;

   int checks = 0;
   int errors = 0;

   fixed_point_sqrt #(.WIDTH(WIDTH), .FBITS(FBITS)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .operand    (operand),
      .root       (root),
      .root_ready (root_ready),
      .busy       (busy),
      .error      (error)
   );

   always #5 clk = ~clk;

   // floor(sqrt(op * 2^FBITS)) by binary search; 0 for negative radicands
   function automatic logic [31:0] ref_root(input logic [31:0] op);
      longint unsigned v, lo, hi, mid;
      if (op[31]) return 32'd0;
      v  = longint'(op) << FBITS;
      lo = 0;
      hi = 64'd1 << 22;
      while (lo < hi) begin
         mid = (lo + hi + 1) / 2;
         if (mid * mid <= v) lo = mid;
         else hi = mid - 1;
      end
      return lo[31:0];
   endfunction

   // Issue one request and wait (bounded) for root_ready; lat counts edges after accept.
   task automatic run_op(input logic [31:0] op, output int lat, output int bcnt, output bit tmo);
      @(negedge clk);
      operand = op;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      operand = $urandom;
      lat = 0; bcnt = 0; tmo = 1'b0;
      while (!root_ready) begin
         if (busy) bcnt++;
         if (lat >= 100) begin tmo = 1'b1; break; end
         @(negedge clk);
         lat++;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; operand = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({root, root_ready, busy, error} !== 35'd0) begin
         errors++;
         $display("FAIL reset_state got root=%h rdy=%b busy=%b err=%b want all 0", root, root_ready, busy, error);
      end
      reset = 1'b0;
   endtask

   task automatic test_directed();
      logic [31:0] ops [6] = '{32'h0000_1000, 32'h0000_0800, 32'h0, 32'h7FFF_FFFF, 32'h0000_0400, 32'h1};
      logic [31:0] exp [6] = '{32'h0000_0800, 32'h0000_05A8, 32'h0, 32'h0016_A09E, 32'h0000_0400, 32'h20};
      int lat, bcnt; bit tmo;
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], lat, bcnt, tmo);
         checks++;
         if (tmo || root !== exp[i] || error !== 1'b0) begin
            errors++;
            $display("FAIL directed[%0d] op=%h got root=%h err=%b tmo=%b want %h err=0", i, ops[i], root, error, tmo, exp[i]);
         end
         checks++;
         if (lat != ITER || bcnt != ITER) begin
            errors++;
            $display("FAIL directed_timing[%0d] got lat=%0d busy=%0d want %0d/%0d", i, lat, bcnt, ITER, ITER);
         end
      end
   endtask

   task automatic test_negative();
      int lat, bcnt; bit tmo;
      run_op(32'h8000_0000, lat, bcnt, tmo);
      checks++;
      if (tmo || root !== 32'd0 || error !== 1'b1 || lat != 1 || bcnt != 0) begin
         errors++;
         $display("FAIL negative got root=%h err=%b lat=%0d busy=%0d want 0/1/1/0", root, error, lat, bcnt);
      end
      run_op(32'h0000_1000, lat, bcnt, tmo);
      checks++;
      if (tmo || root !== 32'h800 || error !== 1'b0) begin
         errors++;
         $display("FAIL neg_recover got root=%h err=%b want 00000800 err=0", root, error);
      end
   endtask

   task automatic test_start_ignored();
      int lat;
      @(negedge clk);
      operand = 32'h0000_1000; start = 1'b1;
      @(negedge clk);
      start = 1'b0; lat = 0;
      repeat (4) begin @(negedge clk); lat++; end
      operand = 32'h0000_0400; start = 1'b1;
      @(negedge clk); lat++;
      start = 1'b0;
      while (!root_ready && lat < 100) begin @(negedge clk); lat++; end
      checks++;
      if (root !== 32'h800 || lat != ITER) begin
         errors++;
         $display("FAIL start_ignored got root=%h lat=%0d want 00000800 lat=%0d", root, lat, ITER);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (root_ready !== 1'b1 || busy !== 1'b0 || root !== 32'h800) begin
         errors++;
         $display("FAIL start_ignored_hold got rdy=%b busy=%b root=%h want 1/0/00000800", root_ready, busy, root);
      end
   endtask

   task automatic test_reset_mid();
      int lat, bcnt, seen; bit tmo;
      @(negedge clk);
      operand = 32'h7FFF_FFFF; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({root, root_ready, busy, error} !== 35'd0) begin
         errors++;
         $display("FAIL reset_mid got root=%h rdy=%b busy=%b err=%b want all 0", root, root_ready, busy, error);
      end
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (30) begin @(negedge clk); if (root_ready || busy) seen++; end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL reset_mid_quiet got %0d active cycles want 0", seen);
      end
      run_op(32'h0000_0800, lat, bcnt, tmo);
      checks++;
      if (tmo || root !== 32'h5A8 || lat != ITER) begin
         errors++;
         $display("FAIL reset_mid_restart got root=%h lat=%0d want 000005a8 lat=%0d", root, lat, ITER);
      end
   endtask

   task automatic test_random();
      logic [31:0] op, exp;
      int lat, bcnt; bit tmo;
      for (int i = 0; i < 40; i++) begin
         op = $urandom;
         if ($urandom_range(3) != 0) op[31] = 1'b0;
         exp = ref_root(op);
         run_op(op, lat, bcnt, tmo);
         checks++;
         if (tmo || root !== exp || error !== op[31] ||
             lat != (op[31] ? 1 : ITER) || bcnt != (op[31] ? 0 : ITER)) begin
            errors++;
            $display("FAIL random[%0d] op=%h got root=%h err=%b lat=%0d busy=%0d want root=%h err=%b",
                     i, op, root, error, lat, bcnt, exp, op[31]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] op_b;
      int lat, bcnt; bit tmo;
      op_b = {1'b0, 31'($urandom)};
      run_op(32'h0012_3456, lat, bcnt, tmo);
      checks++;
      if (tmo || root !== ref_root(32'h0012_3456)) begin
         errors++;
         $display("FAIL b2b_first got root=%h want %h", root, ref_root(32'h0012_3456));
      end
      operand = op_b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (root_ready !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL b2b_drop got rdy=%b busy=%b want 0/1", root_ready, busy);
      end
      lat = 0;
      while (!root_ready && lat < 100) begin @(negedge clk); lat++; end
      checks++;
      if (root !== ref_root(op_b) || lat != ITER) begin
         errors++;
         $display("FAIL b2b_second op=%h got root=%h lat=%0d want %h lat=%0d", op_b, root, lat, ref_root(op_b), ITER);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_negative();
      test_start_ignored();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
